// File: rtl/bram_sdp_ctrl.sv
// Simple dual-port block RAM with per-lane write enables and optional output register.
// Defining BRAM_SDP_CLEAR_EN builds a FLUSH-triggered clear engine that zeroes every word.
module bram_sdp_ctrl #(
    parameter int DATA_WIDTH  = 36,
    parameter int ADDR_WIDTH  = 10,
    parameter int OUT_REG     = 0,
    parameter int WRITE_FIRST = 0,
    localparam int BE_WIDTH   = (DATA_WIDTH <= 9) ? 1 : (DATA_WIDTH <= 18) ? 2 : 4
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  WEN,
    input  logic [ADDR_WIDTH-1:0] WADDR,
    input  logic [DATA_WIDTH-1:0] WDATA,
    input  logic [BE_WIDTH-1:0]   WBE,
    input  logic                  REN,
    input  logic [ADDR_WIDTH-1:0] RADDR,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic                  RVALID,
    input  logic                  FLUSH,
    output logic                  BUSY
);

    localparam int LANE_W = DATA_WIDTH / BE_WIDTH;
    localparam int DEPTH  = 2 ** ADDR_WIDTH;

    // Handshake: a request is taken on any rising edge where its enable is high and BUSY
    // is low; there is no back-pressure, and each taken read yields exactly one RVALID pulse.
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  busy_int;
    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] wr_mask;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] s1_data;
    logic                  s1_valid;

    assign wr_en = WEN && !busy_int;
    assign rd_en = REN && !busy_int;
    assign BUSY  = busy_int;

    always_comb begin
        wr_mask = '0;
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (WBE[i]) wr_mask[i*LANE_W +: LANE_W] = '1;
        end
    end

    // Clear and user writes never coincide: user writes are blocked while BUSY.
    always_ff @(posedge CLK) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < BE_WIDTH; i++) begin
                if (WBE[i]) mem[WADDR][i*LANE_W +: LANE_W] <= WDATA[i*LANE_W +: LANE_W];
            end
        end
    end

    always_comb begin
        rd_word = mem[RADDR];
        if (WRITE_FIRST != 0 && wr_en && (WADDR == RADDR))
            rd_word = (rd_word & ~wr_mask) | (WDATA & wr_mask);
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_en;
            if (rd_en) s1_data <= rd_word;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] s2_data;
            logic                  s2_valid;

            always_ff @(posedge CLK) begin
                if (!RESET_N) begin
                    s2_valid <= 1'b0;
                    s2_data  <= '0;
                end else begin
                    s2_valid <= s1_valid;
                    if (s1_valid) s2_data <= s1_data;
                end
            end

            assign RDATA  = s2_data;
            assign RVALID = s2_valid;
        end else begin : g_no_out_reg
            assign RDATA  = s1_data;
            assign RVALID = s1_valid;
        end
    endgenerate

`ifdef BRAM_SDP_CLEAR_EN
    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    state_t              state;
    state_t              state_next;
    logic [ADDR_WIDTH:0] cnt;

    always_ff @(posedge CLK) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (FLUSH) state_next = CLEAR;
            CLEAR:   if (cnt == (ADDR_WIDTH+1)'(DEPTH - 1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy_int = (state == CLEAR);
        clr_we   = (state == CLEAR);
        clr_addr = cnt[ADDR_WIDTH-1:0];
    end

    // Counter parks at DEPTH after the last word and is reloaded by the next FLUSH.
    always_ff @(posedge CLK) begin
        if (!RESET_N)             cnt <= '0;
        else if (state == CLEAR)  cnt <= cnt + 1'b1;
        else if (FLUSH)           cnt <= '0;
    end
`else
    logic unused_flush;

    assign unused_flush = FLUSH;
    assign busy_int     = 1'b0;
    assign clr_we       = 1'b0;
    assign clr_addr     = '0;
`endif

endmodule
